uart_out_port: RTL and testbench
================================

# uart_out_port

Byte-wide output stage that sits directly downstream of the processor's output register. It captures each byte the core emits on a write strobe into a small FIFO and serialises the bytes onto a single UART TX line (8 data bits, LSB first, 1 stop bit). Together with the core it provides a self-contained "print" path for simulation and FPGA bring-up without stalling the core.

## Interface
Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; legal range is 2 to 65535.
- DEPTH_LOG2, 3, log2 of FIFO depth; default depth is 8 bytes.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-low reset.
- wr_data, input, 8, byte from the processor output register.
- wr_en, input, 1, write strobe; one byte per cycle while high.
- full, output, 1, registered; high when the FIFO holds 2^DEPTH_LOG2 bytes.
- tx, output, 1, registered serial line; idles high.
- busy, output, 1, high while the FIFO is non-empty or a frame is in flight.
- overflow, output, 1, sticky; set when a write is dropped.

## Operation
- FIFO: circular buffer with DEPTH_LOG2-bit read/write pointers and a (DEPTH_LOG2+1)-bit count. Pointers wrap modulo depth.
- Write acceptance:
  - A write with wr_en=1 is accepted if count < depth at the edge, even if a pop happens in the same cycle.
  - Otherwise the byte is dropped and overflow sets.
  - overflow clears only on reset.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If count != 0, pop the head into the shift register, clear the bit counter and baud counter, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right. After 8 bits go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end of STOP:
    - if count != 0, pop and go directly to START (no idle gap);
    - else go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). Terminal count advances the bit.
- Reset (any time, including mid-frame):
  - tx=1, full=0, busy=0, overflow=0.
  - count, pointers and counters = 0, FSM = IDLE.
  - FIFO contents are discarded and the partial frame is abandoned.

## Timing
- Write to line latency, FIFO empty and FSM in IDLE: byte written at edge k; tx goes low at edge k+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles; back-to-back frames have no gap.
- full updates at the same edge as count. With a write at count=depth-1, full is high from that edge.
- busy is combinational from registered state: (state != IDLE) || (count != 0). It falls at the edge that ends the last STOP with an empty FIFO.
- No backpressure to the core: the core must sample full, and drops are reported only through overflow.

## Configuration
- UART_OUT_PARITY_EN:
  - Defined: a PARITY state is inserted between DATA and STOP. It transmits even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles, so a frame is 11*CLKS_PER_BIT cycles.
  - Undefined: no PARITY state; the frame is 10*CLKS_PER_BIT cycles.

## Test plan
All scenarios use CLKS_PER_BIT=4, DEPTH_LOG2=3.
- Single byte: after reset, pulse wr_en with 0x55 at edge k.
  - tx from edge k+1 in 4-cycle bits: 0 | 1,0,1,0,1,0,1,0 | 1.
  - busy low at edge k+41.
- Back-to-back: write 0xA5 then 0x0F on consecutive cycles.
  - Two frames run with no idle gap: 80 cycles total.
  - Second frame data bits are 1,1,1,1,0,0,0,0.
- Full and overflow: while the first frame transmits, write 9 more bytes in 9 consecutive cycles.
  - full rises after the 8th byte stored.
  - The 9th byte is dropped and overflow = 1.
  - Exactly 9 frames are emitted in order.
- Simultaneous push/pop: with count=8, assert wr_en on the cycle STOP ends.
  - The write is dropped (count was full) and overflow sets.
  - count becomes 7.
- Reset mid-frame: assert rst low during DATA bit 3.
  - tx=1, busy=0, full=0 immediately.
  - After release, no residual frame appears.
- Parity (UART_OUT_PARITY_EN defined): write 0x07.
  - Parity bit 1 appears before stop.
  - Frame is 44 cycles.

Source files
------------

// File: rtl/uart_out_port_if.sv
// Write-side bus between the processor output register and uart_out_port.
// The core drives data/strobe and samples full/overflow; there is no backpressure.
interface uart_out_port_if;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic       overflow;

    modport master (
        output wr_data,
        output wr_en,
        input  full,
        input  overflow
    );

    modport slave (
        input  wr_data,
        input  wr_en,
        output full,
        output overflow
    );
endinterface

// File: rtl/uart_out_port.sv
// Byte FIFO plus 8N1 UART transmitter for the processor's print path.
// Optional feature: define UART_OUT_PARITY_EN to add an even-parity bit before stop.
module uart_out_port #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH_LOG2   = 3
) (
    input  logic             clk,
    input  logic             rst,
    uart_out_port_if.slave   bus,
    output logic             tx,
    output logic             busy
);
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0]   BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_OUT_PARITY_EN
        PARITY,
`endif
        STOP
    } state_e;

    state_e                state_q, state_d;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  overflow_q, overflow_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic                  tx_q, tx_d;
`ifdef UART_OUT_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    logic       push;
    logic       pop;
    logic       baud_done;
    logic [7:0] head;

    assign push      = bus.wr_en && (count_q < COUNT_FULL);
    assign baud_done = (baud_q == BAUD_LAST);
    assign head      = mem[rd_ptr_q];

    // NOTE: every signal written here gets a default first, so no latches are inferred.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        pop      = 1'b0;
`ifdef UART_OUT_PARITY_EN
        parity_d = parity_q;
`endif

        if (state_q != IDLE) begin
            baud_d = baud_done ? '0 : baud_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) state_d = DATA;
            end
            DATA: begin
                if (baud_done) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef UART_OUT_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_OUT_PARITY_EN
            PARITY: begin
                if (baud_done) state_d = STOP;
            end
`endif
            STOP: begin
                if (baud_done) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Loading a new frame restarts both counters, from IDLE or straight out of STOP.
        if (pop) begin
            shift_d  = head;
            bit_d    = '0;
            baud_d   = '0;
`ifdef UART_OUT_PARITY_EN
            parity_d = ^head;
`endif
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d     = (count_d == COUNT_FULL);
        overflow_d = overflow_q || (bus.wr_en && !push);

        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_OUT_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
`ifdef UART_OUT_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
`ifdef UART_OUT_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // NOTE: the byte store has no reset; clearing count and pointers already discards it.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.wr_data;
    end

    assign bus.full     = full_q;
    assign bus.overflow = overflow_q;
    assign tx           = tx_q;
    assign busy         = (state_q != IDLE) || (count_q != '0);
endmodule

// File: tb/tb_uart_out_port.sv
// Directed bench for uart_out_port with CLKS_PER_BIT=4, DEPTH_LOG2=3.
// Frames are checked cycle by cycle against hand-derived bit patterns.
module tb_uart_out_port;
    localparam int CPB  = 4;
    localparam int DL2  = 3;
`ifdef UART_OUT_PARITY_EN
    localparam int FB   = 11;
`else
    localparam int FB   = 10;
`endif

    logic clk = 1'b0;
    logic rst;
    logic tx;
    logic busy;

    always #5 clk = ~clk;

    uart_out_port_if bus ();

    uart_out_port #(
        .CLKS_PER_BIT (CPB),
        .DEPTH_LOG2   (DL2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .tx   (tx),
        .busy (busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.wr_data = b;
        bus.wr_en   = 1'b1;
        step();
        bus.wr_en   = 1'b0;
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
`ifdef UART_OUT_PARITY_EN
        if (i == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Entered one step after the edge that drove the start bit; leaves on the last stop cycle.
    task automatic expect_frame(input string tag, input logic [7:0] d);
        for (int c = 0; c < FB * CPB; c++) begin
            chk($sformatf("%s bit%0d cyc%0d", tag, c / CPB, c % CPB), tx, exp_bit(d, c / CPB));
            if (c < FB * CPB - 1) step();
        end
    endtask

    logic [7:0] q [9];
    logic       idle_ok;

    initial begin
        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h66, 8'h77, 8'h88, 8'h99};
        rst         = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        step();
        chk("rst tx", tx, 1'b1);
        chk("rst busy", busy, 1'b0);
        step();
        rst = 1'b1;
        step();
        chk("post-rst tx", tx, 1'b1);
        chk("post-rst busy", busy, 1'b0);
        chk("post-rst full", bus.full, 1'b0);
        chk("post-rst overflow", bus.overflow, 1'b0);

        // Single byte: tx low one edge after the write, busy low 41 edges after it.
        write_byte(8'h55);
        chk("s1 tx before start", tx, 1'b1);
        chk("s1 busy after write", busy, 1'b1);
        step();
        expect_frame("s1", 8'h55);
        chk("s1 busy last stop cycle", busy, 1'b1);
        step();
        chk("s1 busy after frame", busy, 1'b0);
        chk("s1 tx idle", tx, 1'b1);

        // Back-to-back: second start bit immediately follows first stop bit.
        write_byte(8'hA5);
        write_byte(8'h0F);
        expect_frame("s2 f0", 8'hA5);
        step();
        expect_frame("s2 f1", 8'h0F);
        step();
        chk("s2 busy after 2 frames", busy, 1'b0);
        chk("s2 full", bus.full, 1'b0);

        // Fill while frame 0 is on the line; 9th extra byte is dropped.
        write_byte(q[0]);
        fork
            begin
                for (int j = 1; j <= 8; j++) begin
                    write_byte(q[j]);
                    chk($sformatf("s3 full after w%0d", j), bus.full, (j == 8) ? 1'b1 : 1'b0);
                    chk($sformatf("s3 ovf after w%0d", j), bus.overflow, 1'b0);
                end
                write_byte(8'hEE);
                chk("s3 ovf after 9th", bus.overflow, 1'b1);
                chk("s3 full after 9th", bus.full, 1'b1);
            end
            begin
                step();
                expect_frame("s3 f0", q[0]);
            end
        join
        // Write on the edge STOP ends with count=8: dropped, pop still happens.
        write_byte(8'hDD);
        chk("s3 pushpop ovf", bus.overflow, 1'b1);
        chk("s3 pushpop full", bus.full, 1'b0);
        chk("s3 pushpop busy", busy, 1'b1);
        for (int j = 1; j <= 8; j++) begin
            expect_frame($sformatf("s3 f%0d", j), q[j]);
            step();
        end
        chk("s3 busy after 9 frames", busy, 1'b0);
        chk("s3 tx idle", tx, 1'b1);

        // Reset in data bit 3 of 0x34 (that bit is 0) with FIFO full and overflow set.
        write_byte(8'h34);
        for (int j = 1; j <= 9; j++) write_byte(8'(j));
        chk("s4 full before rst", bus.full, 1'b1);
        chk("s4 ovf before rst", bus.overflow, 1'b1);
        repeat (9) step();
        chk("s4 tx in data bit3", tx, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("s4 tx in rst", tx, 1'b1);
        chk("s4 busy in rst", busy, 1'b0);
        chk("s4 full in rst", bus.full, 1'b0);
        chk("s4 ovf in rst", bus.overflow, 1'b0);
        step();
        rst = 1'b1;
        idle_ok = 1'b1;
        repeat (60) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0) idle_ok = 1'b0;
        end
        chk("s4 no residual frame", idle_ok, 1'b1);

        // 0x07: parity bit is 1 when parity is built in.
        write_byte(8'h07);
        step();
        expect_frame("s5", 8'h07);
        chk("s5 busy last stop cycle", busy, 1'b1);
        step();
        chk("s5 busy after frame", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
